// File: rtl/piradip_trigger_capture_if.sv
// piradip_trigger_capture_if: control, trigger and readback signals of the trigger capture block
`timescale 1ns/1ps
interface piradip_trigger_capture_if #(
   parameter int N_TRIGGER     = 8,
   parameter int COUNTER_WIDTH = 32
);
   localparam int RSW = (N_TRIGGER > 1) ? $clog2(N_TRIGGER) : 1;
   logic [N_TRIGGER-1:0]     trig_in;
   logic [N_TRIGGER-1:0]     chan_en;
   logic                     arm;
   logic [COUNTER_WIDTH-1:0] timeout;
   logic                     busy;
   logic                     done;
   logic                     complete;
   logic                     timed_out;
   logic [N_TRIGGER-1:0]     captured;
   logic [N_TRIGGER-1:0]     multi_hit;
   logic [RSW-1:0]           rd_sel;
   logic [COUNTER_WIDTH-1:0] rd_timestamp;
   modport master (
      output trig_in, chan_en, arm, timeout, rd_sel,
      input  busy, done, complete, timed_out, captured, multi_hit, rd_timestamp
   );
   modport slave (
      input  trig_in, chan_en, arm, timeout, rd_sel,
      output busy, done, complete, timed_out, captured, multi_hit, rd_timestamp
   );
endinterface

// File: rtl/piradip_trigger_capture.sv
// piradip_trigger_capture: timestamps the first rising edge per trigger channel relative to an arm pulse
`timescale 1ns/1ps
module piradip_trigger_capture #(
   parameter int N_TRIGGER     = 8,
   parameter int COUNTER_WIDTH = 32,
   parameter int SYNC_STAGES   = 2
) (
   input logic clk,
   input logic rstn,
   piradip_trigger_capture_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
   state_t                   r_state;
   logic [N_TRIGGER-1:0]     r_sync [SYNC_STAGES];
   logic [N_TRIGGER-1:0]     r_prev, r_en, r_cap, r_mh;
   logic [COUNTER_WIDTH-1:0] r_cnt, r_to;
   logic [COUNTER_WIDTH-1:0] r_ts [N_TRIGGER];
   logic                     r_busy, r_done, r_cmp, r_tmo;
   logic [N_TRIGGER-1:0]     w_rise, w_new, w_rep, w_cap_nx;
   logic                     w_all, w_tmo;

   assign w_rise   = r_sync[SYNC_STAGES-1] & ~r_prev;
   assign w_new    = r_en & w_rise & ~r_cap;
   assign w_rep    = r_en & w_rise & r_cap;
   assign w_cap_nx = r_cap | w_new;
   assign w_all    = (w_cap_nx & r_en) == r_en;
   assign w_tmo    = (|r_to && r_cnt == r_to) || &r_cnt;

   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.complete     = r_cmp;
   assign bus.timed_out    = r_tmo;
   assign bus.captured     = r_cap;
   assign bus.multi_hit    = r_mh;
   assign bus.rd_timestamp = (int'(bus.rd_sel) < N_TRIGGER) ? r_ts[bus.rd_sel] : '0;

   // synchronize the asynchronous triggers and keep the previous level for edge detection in every state
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
         r_prev <= '0;
      end else begin
         r_sync[0] <= bus.trig_in;
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   // capture FSM: arm restarts everything, ARMED records first edges until all enabled channels hit or the window ends
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cmp   <= 1'b0;
         r_tmo   <= 1'b0;
         r_cnt   <= '0;
         r_to    <= '0;
         r_en    <= '0;
         r_cap   <= '0;
         r_mh    <= '0;
         for (int i = 0; i < N_TRIGGER; i++) r_ts[i] <= '0;
      end else if (bus.arm) begin
         r_state <= ARMED;
         r_busy  <= 1'b1;
         r_done  <= 1'b0;
         r_cmp   <= 1'b0;
         r_tmo   <= 1'b0;
         r_cnt   <= '0;
         r_to    <= bus.timeout;
         r_en    <= bus.chan_en;
         r_cap   <= '0;
         r_mh    <= '0;
         for (int i = 0; i < N_TRIGGER; i++) r_ts[i] <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ARMED: begin
               r_cnt <= &r_cnt ? r_cnt : r_cnt + 1'b1;
               r_cap <= w_cap_nx;
               r_mh  <= r_mh | w_rep;
               for (int i = 0; i < N_TRIGGER; i++) if (w_new[i]) r_ts[i] <= r_cnt;
               if (w_all || w_tmo) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_cmp   <= w_all;
                  r_tmo   <= !w_all;
               end
            end
            DONE: r_mh <= r_mh | w_rep;
            default: ;
         endcase
      end
   end
endmodule

// File: doc/piradip_trigger_capture.md
# piradip_trigger_capture

Receive-side counterpart to the PiRadIP delayed-trigger generator. It timestamps the first rising edge on each of N trigger inputs relative to a common arm pulse, then reports per-channel capture status, multi-hit flags and cycle-accurate timestamps. It sits on the consumer side of the trigger fabric, for example at an ADC/DAC capture front-end or a loopback measurement point, and can measure trigger skew and programmed delays in-system.

## Interface
Parameters:
- N_TRIGGER, 8, number of trigger input channels (1..32)
- COUNTER_WIDTH, 32, width of the cycle counter, the timeout and the timestamps
- SYNC_STAGES, 2, flip-flop synchronizer depth per input (>= 2)

Ports:
- clk  in  1  capture clock
- rstn  in  1  synchronous, active-low reset
- trig_in  in  N_TRIGGER  asynchronous trigger inputs
- chan_en  in  N_TRIGGER  channel enable mask, latched on arm
- arm  in  1  single-cycle start pulse
- timeout  in  COUNTER_WIDTH  capture window in cycles; 0 = no timeout, latched on arm
- busy  out  1  high while in ARMED
- done  out  1  one-cycle pulse on entry to DONE
- complete  out  1  sticky: every enabled channel captured
- timed_out  out  1  sticky: window expired before completion
- captured  out  N_TRIGGER  per-channel first-edge-captured flags
- multi_hit  out  N_TRIGGER  per-channel flag for a second rising edge after capture
- rd_sel  in  $clog2(N_TRIGGER) (min 1)  timestamp read select
- rd_timestamp  out  COUNTER_WIDTH  timestamp of channel rd_sel; combinational; 0 if not captured or rd_sel >= N_TRIGGER

## Operation
- States: IDLE, ARMED, DONE. Reset puts the block in IDLE. All outputs reset to 0, and all timestamps reset to 0.
- Input path: each trig_in bit passes a SYNC_STAGES flip-flop synchronizer, then a prev register. rise[i] = sync[i] & ~prev[i]. The prev register updates every cycle in every state, so a level that is already high at arm time is never a rise.
- arm sampled high in any state:
  - next state ARMED
  - counter <= 0
  - captured, multi_hit, complete, timed_out <= 0
  - timestamps <= 0
  - en_q <= chan_en, to_q <= timeout
  - arm takes priority over every other event in that cycle.
- ARMED, each cycle:
  - counter increments and saturates at all-ones.
  - For each i with en_q[i] & rise[i]: if captured[i]=0, store ts[i] <= counter and set captured[i]. Otherwise set multi_hit[i].
  - Disabled channels never capture and never set multi_hit.
- Exit from ARMED is evaluated on the cycle's next-state values:
  - If (captured_next & en_q) == en_q, go to DONE with complete=1. This includes en_q = 0, which finishes one cycle after arm.
  - Else, if to_q != 0 and counter == to_q, go to DONE with timed_out=1.
  - Else, if counter is all-ones, go to DONE with timed_out=1.
  - When completion and timeout occur in the same cycle, completion wins: complete=1, timed_out=0.
- DONE: the counter holds, flags hold, and multi_hit keeps updating for enabled channels. Only arm or reset leaves DONE.
- IDLE: no capture and no flag updates.
- Reset mid-capture: next cycle is IDLE with all outputs 0, and any pending capture is discarded.

## Timing
- arm sampled at clock edge e0: busy=1 and counter=0 after e0, and counter=j after e_j.
- Capture latency from a synchronous trig_in rise to the captured bit is SYNC_STAGES+1 cycles.
- Timestamp rule: trig_in first high D cycles after the arm-high cycle gives ts = D + SYNC_STAGES - 1. This holds for all D >= 1 - SYNC_STAGES; earlier edges are lost.
- A timeout of T gives the transition to DONE at edge e_{T+1}: done pulses and busy falls in the cycle after e_{T+1}. Captures detected in that same cycle are still recorded.
- done is high for exactly one cycle per DONE entry. Re-arming in DONE gives a new pulse on the next completion.
- The complete/timed_out flags and captured are valid in the same cycle as done.

## Test plan
- Basic capture, SYNC_STAGES=2, chan_en=0xFF, timeout=0, arm; trig_in[k] rises D=10+k cycles after arm for k=0..7 -> ts[k]=11+k, complete=1, timed_out=0, done pulses once in the cycle after ch7 is captured.
- Timeout, chan_en=0x03, timeout=100; only ch0 rises at D=5 -> captured=0x01, ts[0]=6, timed_out=1, done at cycle 101 after arm; rd_timestamp for ch1 reads 0.
- Pre-high level and multi-hit: trig_in[2] held high before arm, then pulsed low-high-low-high after arm -> first re-rise captured, later rise sets multi_hit[2], ts[2] matches the first re-rise.
- Simultaneous events: the last enabled channel's rise is detected on the timeout cycle -> complete=1, timed_out=0. Also arm while ARMED with pending captures -> all flags cleared and counter restarts at 0.
- Disabled/empty mask: chan_en=0x00, arm -> DONE one cycle later with complete=1. Edges on disabled channels never set captured or multi_hit.
- Reset mid-capture: rstn low for one cycle during ARMED -> IDLE with busy, captured, multi_hit and flags all 0. A subsequent arm behaves exactly as a first arm after reset.
